// File: rtl/caliptra_prim_prio_dispatch.sv
// caliptra_prim_prio_dispatch: sticky pending-request tracker that registers the max-tree winner
// as a grant, offers it on a valid/ready handshake and clears the winner's flag on accept.
module caliptra_prim_prio_dispatch #(
    parameter int NumSrc    = 32,
    parameter int Width     = 8,
    parameter int GapCycles = 2,
    parameter int SrcWidth  = $clog2(NumSrc)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumSrc-1:0]   req_i,
    input  logic [NumSrc-1:0]   en_i,
    input  logic                clr_i,
    input  logic [Width-1:0]    thresh_i,
    output logic [NumSrc-1:0]   pend_o,
    input  logic                max_valid_i,
    input  logic [SrcWidth-1:0] max_idx_i,
    input  logic [Width-1:0]    max_value_i,
    output logic                gnt_valid_o,
    input  logic                gnt_ready_i,
    output logic [SrcWidth-1:0] gnt_idx_o,
    output logic [Width-1:0]    gnt_value_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {IDLE, OFFER, GAP} state_e;

    state_e              state_q, state_d;
    logic [NumSrc-1:0]   pend_q, pend_d, acc_mask;
    logic [SrcWidth-1:0] gnt_idx_q, gnt_idx_d;
    logic [Width-1:0]    gnt_value_q, gnt_value_d;
    logic                accept, win_ok, gap_done;

    assign accept   = (state_q == OFFER) && gnt_ready_i;
    assign acc_mask = accept ? (NumSrc'(1) << gnt_idx_q) : '0;
    // New requests are ORed in last so a same-cycle set beats accept/flush clears.
    assign pend_d   = (pend_q & ~({NumSrc{clr_i}} | acc_mask)) | req_i;
    assign win_ok   = max_valid_i && (max_value_i > thresh_i) &&
                      ({1'b0, max_idx_i} < (SrcWidth+1)'(NumSrc));

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_value_d = gnt_value_q;
        case (state_q)
            IDLE: begin
                if (win_ok) begin
                    state_d     = OFFER;
                    gnt_idx_d   = max_idx_i;
                    gnt_value_d = max_value_i;
                end
            end
            OFFER: begin
                if (gnt_ready_i) begin
                    if (GapCycles > 0) state_d = GAP;
                    else               state_d = IDLE;
                end
            end
            GAP:     if (gap_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            gnt_idx_q   <= '0;
            gnt_value_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_value_q <= gnt_value_d;
        end
    end

    if (GapCycles > 0) begin : g_gap
        localparam int CntW = $clog2(GapCycles + 1);
        logic [CntW-1:0] cnt_q;
        always_ff @(posedge clk_i) begin
            if (rst_i)                              cnt_q <= '0;
            else if (accept)                        cnt_q <= CntW'(GapCycles - 1);
            else if (state_q == GAP && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        assign gap_done = (cnt_q == '0);
    end else begin : g_nogap
        assign gap_done = 1'b1;
    end

    assign pend_o      = pend_q & en_i;
    assign gnt_valid_o = (state_q == OFFER);
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_value_o = gnt_value_q;
    assign busy_o      = (state_q != IDLE);

endmodule
